// File: rtl/cpu_pkg.sv
// Shared constants for the Mini SRC control sequencer: opcodes, state encoding,
// and the instruction-class one-hot layout produced by instr_decode.
package cpu_pkg;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned CLS_W = 14;

    typedef logic [OP_W-1:0]  opcode_t;
    typedef logic [ST_W-1:0]  state_t;
    typedef logic [CLS_W-1:0] cls_t;

    // Mini SRC opcodes
    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_LDI  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ROR  = 5'b00111;
    localparam opcode_t OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001;
    localparam opcode_t OP_SHRA = 5'b01010;
    localparam opcode_t OP_SHL  = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ANDI = 5'b01101;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_DIV  = 5'b01111;
    localparam opcode_t OP_MUL  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;
    localparam opcode_t OP_BR   = 5'b10011;
    localparam opcode_t OP_JR   = 5'b10100;
    localparam opcode_t OP_JAL  = 5'b10101;
    localparam opcode_t OP_IN   = 5'b10110;
    localparam opcode_t OP_OUT  = 5'b10111;
    localparam opcode_t OP_MFHI = 5'b11000;
    localparam opcode_t OP_MFLO = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    // ALU select used for address and branch-target arithmetic
    localparam opcode_t ALU_ADD = OP_ADD;

    // Sequencer states
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;

    // Bit positions within the instruction-class one-hot
    localparam int unsigned C_LD     = 0;
    localparam int unsigned C_LDI    = 1;
    localparam int unsigned C_ST     = 2;
    localparam int unsigned C_RTYPE  = 3;
    localparam int unsigned C_IMM    = 4;
    localparam int unsigned C_MULDIV = 5;
    localparam int unsigned C_NEGNOT = 6;
    localparam int unsigned C_BR     = 7;
    localparam int unsigned C_JR     = 8;
    localparam int unsigned C_IN     = 9;
    localparam int unsigned C_OUT    = 10;
    localparam int unsigned C_MF     = 11;
    localparam int unsigned C_NOP    = 12;
    localparam int unsigned C_HALT   = 13;

endpackage

// File: rtl/instr_decode.sv
// Opcode to instruction-class one-hot; jal and the unused 111xx codes fold into
// the no-execute class.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [CLS_W-1:0] cls_c
);

    always_comb begin
        cls_c = '0;
        case (op)
            OP_LD:   cls_c[C_LD]  = 1'b1;
            OP_LDI:  cls_c[C_LDI] = 1'b1;
            OP_ST:   cls_c[C_ST]  = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:
                     cls_c[C_RTYPE] = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:
                     cls_c[C_IMM] = 1'b1;
            OP_MUL, OP_DIV:
                     cls_c[C_MULDIV] = 1'b1;
            OP_NEG, OP_NOT:
                     cls_c[C_NEGNOT] = 1'b1;
            OP_BR:   cls_c[C_BR]  = 1'b1;
            OP_JR:   cls_c[C_JR]  = 1'b1;
            OP_IN:   cls_c[C_IN]  = 1'b1;
            OP_OUT:  cls_c[C_OUT] = 1'b1;
            OP_MFHI, OP_MFLO:
                     cls_c[C_MF]  = 1'b1;
            OP_HALT: cls_c[C_HALT] = 1'b1;
            default: cls_c[C_NOP] = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: fetch T0-T2, execute T3-T7, Moore decode of
// every datapath control from the state register and IR.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic        Clock,
    input  logic        clear_n,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  opcode,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Inportin,
    output logic        Outportin,
    output logic        CONin,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        Inportout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        IncPC
);

    localparam int unsigned CNT_W = (RESET_PC_HOLD < 2) ? 1 : $clog2(RESET_PC_HOLD + 1);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic [CLS_W-1:0] cls;
    logic             last_c;
    logic             alu_c;
    logic [ST_W-1:0]  boundary_c;
    logic             ir_unused;

    assign ir_unused = ^IR[26:0];

    instr_decode u_decode (
        .op    (IR[31:27]),
        .cls_c (cls)
    );

    // State register and reset-hold counter
    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= S_RESET;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Final execute step of each instruction class
    always_comb begin
        last_c = 1'b0;
        case (state)
            S_T3:    last_c = cls[C_JR] | cls[C_IN] | cls[C_OUT] | cls[C_MF];
            S_T4:    last_c = cls[C_NEGNOT];
            S_T5:    last_c = cls[C_RTYPE] | cls[C_IMM] | cls[C_LDI];
            S_T6:    last_c = cls[C_MULDIV] | cls[C_BR];
            S_T7:    last_c = 1'b1;
            default: last_c = 1'b0;
        endcase
    end

    // Stop only takes effect where the next state would otherwise be T0
    assign boundary_c = Stop ? S_HALT : S_T0;

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            S_RESET: begin
                if (hold_cnt == CNT_W'(RESET_PC_HOLD)) begin
                    state_nxt = boundary_c;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            S_T0: state_nxt = S_T1;
            S_T1: state_nxt = S_T2;
            S_T2: begin
                if (cls[C_HALT]) begin
                    state_nxt = S_HALT;
                end else if (cls[C_NOP]) begin
                    state_nxt = boundary_c;
                end else begin
                    state_nxt = S_T3;
                end
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                state_nxt = last_c ? boundary_c : state + ST_W'(1);
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

    assign alu_c = cls[C_RTYPE] | cls[C_IMM] | cls[C_MULDIV] | cls[C_NEGNOT];

    // Output decode
    always_comb begin
        Run = 1'b0;       opcode = '0;
        Gra = 1'b0;       Grb = 1'b0;       Grc = 1'b0;
        Rin = 1'b0;       Rout = 1'b0;      BAout = 1'b0;
        HIin = 1'b0;      LOin = 1'b0;      Yin = 1'b0;       Zin = 1'b0;
        PCin = 1'b0;      IRin = 1'b0;      MARin = 1'b0;     MDRin = 1'b0;
        Inportin = 1'b0;  Outportin = 1'b0; CONin = 1'b0;
        HIout = 1'b0;     LOout = 1'b0;     Zhighout = 1'b0;  Zlowout = 1'b0;
        PCout = 1'b0;     MDRout = 1'b0;    Inportout = 1'b0; Cout = 1'b0;
        Read = 1'b0;      Write = 1'b0;     IncPC = 1'b0;

        case (state)
            S_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; PCin = 1'b1; IncPC = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (alu_c) opcode = IR[31:27];
                if (cls[C_RTYPE] | cls[C_IMM]) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                if (cls[C_LD] | cls[C_LDI] | cls[C_ST]) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
                if (cls[C_MULDIV]) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
                if (cls[C_NEGNOT]) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end
                if (cls[C_BR]) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end
                if (cls[C_JR]) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
                if (cls[C_IN]) begin
                    Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[C_OUT]) begin
                    Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1;
                end
                if (cls[C_MF]) begin
                    HIout = ~IR[27]; LOout = IR[27]; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (alu_c) opcode = IR[31:27];
                if (cls[C_RTYPE]) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end
                if (cls[C_IMM]) begin
                    Cout = 1'b1; Zin = 1'b1;
                end
                if (cls[C_LD] | cls[C_LDI] | cls[C_ST]) begin
                    Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD;
                end
                if (cls[C_MULDIV]) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                end
                if (cls[C_NEGNOT]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[C_BR]) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                Run = 1'b1;
                if (alu_c) opcode = IR[31:27];
                if (cls[C_RTYPE] | cls[C_IMM] | cls[C_LDI]) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[C_LD] | cls[C_ST]) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end
                if (cls[C_MULDIV]) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end
                if (cls[C_BR]) begin
                    Cout = 1'b1; Zin = 1'b1; opcode = ALU_ADD;
                end
            end
            S_T6: begin
                Run = 1'b1;
                if (alu_c) opcode = IR[31:27];
                if (cls[C_LD]) begin
                    Read = 1'b1; MDRin = 1'b1;
                end
                if (cls[C_ST]) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
                if (cls[C_MULDIV]) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
                // Branch target is committed only when the condition holds
                if (cls[C_BR]) begin
                    Zlowout = 1'b1; PCin = CON_FF;
                end
            end
            S_T7: begin
                Run = 1'b1;
                if (alu_c) opcode = IR[31:27];
                if (cls[C_LD]) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
                if (cls[C_ST]) Write = 1'b1;
            end
            default: Run = 1'b0;
        endcase
    end

endmodule
